// File: rtl/debug_pkg.sv
// Shared definitions for the debug sequencer slice.
// Holds the sequencer state encoding, the "no controller addressed" ID and
// the default widths/depths used by debug_sequencer, its frame FIFO and the
// host-side interface.
package debug_pkg;

    localparam int unsigned NB_CONTROL_FRAME_DEF = 32;
    localparam int unsigned N_CONTROLLERS_DEF    = 3;
    localparam int unsigned NB_ID_DEF            = 6;
    localparam int unsigned FIFO_DEPTH_DEF       = 16;
    localparam int unsigned TIMEOUT_DEF          = 255;

    // Value driven on o_request_select when no controller is addressed.
    localparam int unsigned ID_NONE = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT,
        ST_STREAM,
        ST_NEXT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/debug_sequencer_if.sv
// Host-side frame handshake of the debug sequencer.
//   o_frame : FIFO head frame presented to the host
//   o_valid : o_frame holds a frame
//   i_ready : host accepts o_frame this cycle
// master = sequencer (frame source), slave = host interface (frame sink).
interface debug_sequencer_if #(
    parameter int unsigned NB_CONTROL_FRAME = debug_pkg::NB_CONTROL_FRAME_DEF
);

    logic [NB_CONTROL_FRAME-1:0] o_frame;
    logic                        o_valid;
    logic                        i_ready;

    modport master (
        output o_frame,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_frame,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/debug_frame_fifo.sv
// First-word-fall-through frame buffer for the debug sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the buffer)
//   push, push_data : write request and frame; ignored when full unless a
//                     pop happens in the same cycle
//   pop        : remove head (ignored when empty)
//   full, empty: occupancy flags
//   head       : current head frame, valid whenever empty is low
module debug_frame_fifo
    import debug_pkg::*;
#(
    parameter int unsigned NB_CONTROL_FRAME = NB_CONTROL_FRAME_DEF,
    parameter int unsigned FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [NB_CONTROL_FRAME-1:0] push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [NB_CONTROL_FRAME-1:0] head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [NB_CONTROL_FRAME-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        do_push;
    logic                        do_pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/debug_sequencer.sv
// Debug sequencer: on a host start pulse, addresses debug controllers
// 1..N_CONTROLLERS in turn, buffers every frame each one streams, then
// waits for the host to drain the buffer and pulses o_done.
// Ports:
//   i_clock, i_reset   : clock, asynchronous active-low reset
//   i_start            : host start pulse (only honoured when idle)
//   i_frames           : controller frames, slice k belongs to ID k+1
//   i_writing          : per-controller writing flags, bit k = ID k+1
//   o_request_select   : addressed controller ID, 0 = none
//   host               : frame/valid/ready handshake towards the host
//   o_busy             : high whenever not idle
//   o_done             : one-cycle pulse at end of a dump
//   o_error            : bit0 sticky timeout, bit1 sticky overflow
module debug_sequencer
    import debug_pkg::*;
#(
    parameter int unsigned NB_CONTROL_FRAME = NB_CONTROL_FRAME_DEF,
    parameter int unsigned N_CONTROLLERS    = N_CONTROLLERS_DEF,
    parameter int unsigned NB_ID            = NB_ID_DEF,
    parameter int unsigned FIFO_DEPTH       = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT          = TIMEOUT_DEF
) (
    input  logic                                      i_clock,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic [N_CONTROLLERS*NB_CONTROL_FRAME-1:0] i_frames,
    input  logic [N_CONTROLLERS-1:0]                  i_writing,
    output logic [NB_ID-1:0]                          o_request_select,
    debug_sequencer_if.master                         host,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [1:0]                                o_error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t                      state_q, state_d;
    logic [NB_ID-1:0]            id_q, id_d;
    logic [TW-1:0]               cnt_q, cnt_d;
    logic [1:0]                  err_q, err_d;

    logic [NB_CONTROL_FRAME-1:0] sel_frame;
    logic                        sel_writing;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        drop;

    debug_frame_fifo #(
        .NB_CONTROL_FRAME (NB_CONTROL_FRAME),
        .FIFO_DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clock),
        .rst_n     (i_reset),
        .push      (push),
        .push_data (sel_frame),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (host.o_frame)
    );

    assign host.o_valid = !fifo_empty;
    assign pop          = host.o_valid && host.i_ready;
    // Controllers cannot be stalled: a push into a full buffer with no
    // simultaneous pop is lost and flagged.
    assign drop         = push && fifo_full && !pop;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_error      = err_q;

    // Only the addressed controller's flag and frame are visible.
    always_comb begin
        sel_frame   = '0;
        sel_writing = 1'b0;
        for (int unsigned k = 0; k < N_CONTROLLERS; k++) begin
            if (id_q == NB_ID'(k + 1)) begin
                sel_frame   = i_frames[k*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];
                sel_writing = i_writing[k];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            id_q    <= NB_ID'(1);
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        id_d             = id_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        push             = 1'b0;
        o_done           = 1'b0;
        o_request_select = NB_ID'(ID_NONE);

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SELECT;
                    id_d    = NB_ID'(1);
                    err_d   = '0;
                end
            end
            ST_SELECT: begin
                o_request_select = id_q;
                cnt_d            = '0;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                // cnt_q counts WAIT cycles already spent; TIMEOUT cycles max.
                o_request_select = id_q;
                if (sel_writing) begin
                    push    = 1'b1;
                    state_d = ST_STREAM;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                o_request_select = id_q;
                if (sel_writing) begin
                    push = 1'b1;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                o_request_select = id_q;
                if (id_q == NB_ID'(N_CONTROLLERS)) begin
                    state_d = ST_DRAIN;
                end else begin
                    id_d    = id_q + 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop) begin
            err_d[1] = 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_sequencer.sv
// Self-checking bench for debug_sequencer: emulated controllers stream
// random frames when addressed, a queue model of the frame buffer predicts
// o_valid/o_frame every cycle, and each dump is checked for selection order,
// delivered frames, error flags and a single o_done pulse.
module tb_debug_sequencer;
    import debug_pkg::*;

    localparam int NB    = 32;
    localparam int NC    = 3;
    localparam int NBID  = 6;
    localparam int DEPTH = 16;
    localparam int TMO   = 255;
    localparam int MAXF  = 12;
    localparam int BOUND = 5000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NC*NB-1:0] frames_in = '0;
    logic [NC-1:0]   writing = '0;
    logic [NBID-1:0] sel;
    logic            busy;
    logic            done;
    logic [1:0]      err;

    debug_sequencer_if #(.NB_CONTROL_FRAME(NB)) hif ();

    debug_sequencer #(
        .NB_CONTROL_FRAME (NB),
        .N_CONTROLLERS    (NC),
        .NB_ID            (NBID),
        .FIFO_DEPTH       (DEPTH),
        .TIMEOUT          (TMO)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_start          (start),
        .i_frames         (frames_in),
        .i_writing        (writing),
        .o_request_select (sel),
        .host             (hif),
        .o_busy           (busy),
        .o_done           (done),
        .o_error          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scenario configuration and controller emulation state.
    int          n_fr[NC];
    int          dly_cfg[NC];
    logic [NB-1:0] fr[NC][MAXF];
    int          phase[NC];
    int          dly[NC];
    int          sent[NC];
    int          sel_cycles[NC];
    int          ready_mode = 0;
    bit          spur = 1'b0;
    bit          kick = 1'b0;
    bit          burst_active = 1'b0;
    logic [NB-1:0] burst_frame = '0;
    logic [NB-1:0] mq[$];
    logic [NB-1:0] acc[$];
    logic [NB-1:0] got[$];
    int          sel_log[$];
    int          done_cnt = 0;
    bit          m_ovf = 1'b0;
    logic [NBID-1:0] last_sel = '0;

    typedef struct {
        int n0, n1, n2;
        int rmode;     // 0 always ready, 1 random, 2 held off until drain, 3 held off until full
        bit sp;        // spurious writing flags and start pulses
        int exp_err;   // -1: taken from the queue model
    } vec_t;

    task automatic clear_run();
        for (int k = 0; k < NC; k++) begin
            phase[k] = 0; dly[k] = 0; sent[k] = 0; sel_cycles[k] = 0;
        end
        acc.delete(); got.delete(); sel_log.delete();
        done_cnt = 0; m_ovf = 1'b0; last_sel = '0; kick = 1'b0;
        hif.i_ready = 1'b0;
    endtask

    task automatic drive();
        int k;
        writing = '0;
        burst_active = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NC; i++) frames_in[i*NB +: NB] = $urandom;
        if (!rst_n) begin
            hif.i_ready = 1'b0;
            return;
        end
        if (kick) begin
            start = 1'b1;
            kick = 1'b0;
        end else if (spur && busy && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
        end
        k = int'(sel) - 1;
        if (k >= 0 && k < NC) begin
            if (phase[k] == 0) begin
                phase[k] = 1;
                dly[k] = dly_cfg[k];
            end else if (phase[k] == 1) begin
                if (dly[k] > 0) dly[k]--;
                if (dly[k] == 0 && n_fr[k] > 0) phase[k] = 2;
            end
            if (phase[k] == 2) begin
                if (sent[k] < n_fr[k]) begin
                    writing[k] = 1'b1;
                    frames_in[k*NB +: NB] = fr[k][sent[k]];
                    burst_frame = fr[k][sent[k]];
                    burst_active = 1'b1;
                    sent[k]++;
                end else begin
                    phase[k] = 3;
                end
            end
        end
        if (spur) begin
            for (int i = 0; i < NC; i++)
                if (i != k && $urandom_range(0, 1) == 1) writing[i] = 1'b1;
        end
        case (ready_mode)
            0: hif.i_ready = 1'b1;
            1: hif.i_ready = 1'($urandom_range(0, 1));
            2: hif.i_ready = (sel == '0) && busy;
            default: hif.i_ready = hif.i_ready || (mq.size() == DEPTH);
        endcase
        if (hif.i_ready && hif.o_valid) got.push_back(hif.o_frame);
    endtask

    // Checker + driver, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("valid", hif.o_valid, mq.size() > 0);
            if (mq.size() > 0) chk("head_frame", hif.o_frame, mq[0]);
            if (done) done_cnt++;
            if (sel != '0 && int'(sel) <= NC) sel_cycles[int'(sel) - 1]++;
            if (sel != last_sel && sel != '0) begin
                sel_log.push_back(int'(sel));
                if (sel == 1) chk("err_cleared_at_start", err, 2'b00);
            end
            last_sel = sel;
        end
        drive();
    end

    // Frame buffer reference: a bounded queue updated from the bench's own
    // stimulus (pop when ready and non-empty, then push or drop).
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (hif.i_ready && mq.size() > 0) void'(mq.pop_front());
            if (burst_active) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(burst_frame);
                    acc.push_back(burst_frame);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic setup(input vec_t v);
        clear_run();
        n_fr[0] = v.n0; n_fr[1] = v.n1; n_fr[2] = v.n2;
        ready_mode = v.rmode;
        spur = v.sp;
        for (int k = 0; k < NC; k++) begin
            dly_cfg[k] = $urandom_range(1, 6);
            for (int j = 0; j < MAXF; j++) fr[k][j] = $urandom;
        end
    endtask

    task automatic run(input vec_t v);
        int cyc;
        logic [NB-1:0] expq[$];
        logic [1:0] exp_e;
        bit any_zero;
        setup(v);
        kick = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("done_within_bound", cyc < BOUND, 1);
        chk("done_pulses", done_cnt, 1);
        chk("idle_after_done", busy, 0);
        chk("select_count", sel_log.size(), NC);
        for (int i = 0; i < sel_log.size() && i < NC; i++) chk("select_order", sel_log[i], i + 1);
        any_zero = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (n_fr[k] == 0) begin
                any_zero = 1'b1;
                chk("timeout_len", sel_cycles[k], TMO + 2);
            end
        end
        if (v.exp_err >= 0) begin
            exp_e = 2'(v.exp_err);
            for (int k = 0; k < NC; k++)
                for (int j = 0; j < n_fr[k]; j++)
                    if (!exp_e[1] || expq.size() < DEPTH) expq.push_back(fr[k][j]);
        end else begin
            exp_e = {m_ovf, any_zero};
            expq = acc;
        end
        chk("error_flags", err, exp_e);
        chk("frames_out", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) chk("frame_order", got[i], expq[i]);
    endtask

    vec_t vecs[7];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vec_t v;
        vecs[0] = '{n0: 3,  n1: 4, n2: 5, rmode: 0, sp: 1'b0, exp_err: 0};
        vecs[1] = '{n0: 3,  n1: 0, n2: 2, rmode: 0, sp: 1'b0, exp_err: 1};
        vecs[2] = '{n0: 6,  n1: 7, n2: 7, rmode: 2, sp: 1'b0, exp_err: 2};
        vecs[3] = '{n0: 10, n1: 8, n2: 4, rmode: 3, sp: 1'b0, exp_err: 0};
        vecs[4] = '{n0: 4,  n1: 5, n2: 3, rmode: 0, sp: 1'b1, exp_err: 0};
        vecs[5] = '{n0: 0,  n1: 0, n2: 0, rmode: 0, sp: 1'b0, exp_err: 1};
        vecs[6] = '{n0: 2,  n1: 6, n2: 4, rmode: 1, sp: 1'b1, exp_err: -1};

        clear_run();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_select", sel, 0);
        chk("reset_valid", hif.o_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            v.n0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            v.n1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            v.n2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            v.rmode = $urandom_range(0, 1);
            v.sp = 1'($urandom_range(0, 1));
            v.exp_err = -1;
            run(v);
        end

        // Asynchronous reset while controller 2 is streaming.
        v = '{n0: 0, n1: 6, n2: 4, rmode: 2, sp: 1'b0, exp_err: 0};
        setup(v);
        kick = 1'b1;
        cyc = 0;
        while (!(phase[1] == 2 && sent[1] >= 3) && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_stream_id2", cyc < BOUND, 1);
        #1;
        chk("pre_reset_select", sel, 2);
        chk("pre_reset_valid", hif.o_valid, 1);
        chk("pre_reset_error", err, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", hif.o_valid, 0);
        chk("async_reset_select", sel, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        chk("async_reset_error", err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 SHALL have parameter NB_CONTROL_FRAME, default 32, frame width in bits.
REQ-002 SHALL have parameter N_CONTROLLERS, default 3, number of debug_control instances served (IDs 1..N_CONTROLLERS).
REQ-003 SHALL have parameter NB_ID, default 6, request_select width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two, frame buffer depth.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles waiting for a controller to start writing.
REQ-006 SHALL have port i_clock  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port i_reset  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_start  in  1  one-cycle pulse from host: dump all controllers.
REQ-009 SHALL have port i_frames  in  N_CONTROLLERS*NB_CONTROL_FRAME  controller frames; controller k (ID k+1) occupies slice k.
REQ-010 SHALL have port i_writing  in  N_CONTROLLERS  per-controller writing flags; bit k = ID k+1.
REQ-011 SHALL have port o_request_select  out  NB_ID  ID of the currently addressed controller, 0 = none.
REQ-012 SHALL have port o_frame  out  NB_CONTROL_FRAME  FIFO head frame to the host interface.
REQ-013 SHALL have port o_valid  out  1  o_frame valid.
REQ-014 SHALL have port i_ready  in  1  host interface accepts o_frame.
REQ-015 SHALL have ports o_busy (1, high outside IDLE), o_done (1, one-cycle pulse), o_error (2: bit0 sticky timeout, bit1 sticky overflow).

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, WAIT, STREAM, NEXT, DRAIN.
REQ-017 IDLE: o_request_select=0; i_start -> SELECT with id=1, clears o_error; i_start outside IDLE SHALL be ignored.
REQ-018 SELECT: drive o_request_select=id for one cycle, clear timeout counter, -> WAIT.
REQ-019 WAIT: o_request_select=id held; i_writing[id-1]=1 -> STREAM, capturing that cycle's frame; counter reaching TIMEOUT -> set o_error[0], -> NEXT.
REQ-020 STREAM: every cycle i_writing[id-1]=1 SHALL push i_frames slice id-1 into the FIFO; first cycle it is 0 -> NEXT.
REQ-021 NEXT: id==N_CONTROLLERS -> DRAIN, else id+1 -> SELECT.
REQ-022 DRAIN: o_request_select=0; FIFO empty -> o_done=1 for one cycle, -> IDLE.
REQ-023 Controllers cannot be stalled: push with FIFO full SHALL drop the frame and set o_error[1]; sequencing continues.
REQ-024 o_valid SHALL equal FIFO non-empty; pop occurs on o_valid&&i_ready; o_frame SHALL be the head (first-word-fall-through, zero-cycle read latency).
REQ-025 Simultaneous push and pop when full SHALL succeed (no drop); when empty, push only, o_valid rises next cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy count width clog2(FIFO_DEPTH)+1.
REQ-027 i_writing bits of non-addressed controllers SHALL be ignored.

Reset
REQ-028 i_reset low SHALL immediately force IDLE, id=1, FIFO empty, o_request_select=0, o_valid=0, o_busy=0, o_done=0, o_error=0, regardless of state; buffered frames are discarded.

Structure
REQ-029 State encoding, ID_NONE=0 and default widths SHALL live in shared package debug_pkg.
REQ-030 FIFO SHALL be sub-module debug_frame_fifo (NB_CONTROL_FRAME, FIFO_DEPTH; push/pop/full/empty/head); sequencer is FSM plus mux.

Verification
REQ-031 Start, three controllers emit 3/4/5 frames, i_ready=1 -> select 1,2,3 in order, 12 frames out in order, o_done once, o_error=0.
REQ-032 Controller 2 never writes -> o_error=2'b01 after 255 WAIT cycles, controller 3 still served, o_done asserted.
REQ-033 i_ready=0 throughout, 20 frames total -> 16 buffered, o_error=2'b10, first 16 frames output intact once i_ready=1, then o_done.
REQ-034 Full FIFO with push and pop same cycle -> no drop, count stays 16, o_error[1]=0.
REQ-035 i_reset low during STREAM of controller 2 -> next edge-independent: o_valid=0, o_request_select=0, o_busy=0; new i_start restarts at ID 1.
REQ-036 i_start pulsed during STREAM and spurious i_writing[0] while ID 2 selected -> both ignored, frame count unchanged.
